// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a skewed block pipeline.
// The design has an input register stage followed by one lookahead block per stage.
// Each block forwards its carry to the next stage. Flow control is a single global stall.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned NBLK = WIDTH / BLOCK;

    // Reject block sizes that do not tile the operand width
    generate
        if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_params
            $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of BLOCK");
        end
    endgenerate

    // Stage k holds operands, incoming block carry and the sum bits of blocks < k
    logic [NBLK-1:0]  stg_vld;
    logic [WIDTH-1:0] stg_a   [NBLK];
    logic [WIDTH-1:0] stg_b   [NBLK];
    logic [WIDTH-1:0] stg_sum [NBLK];
    logic [NBLK-1:0]  stg_c;

    // Per-stage block results: merged sum, block carry-out, carry into block MSB
    logic [WIDTH-1:0] nxt_sum [NBLK];
    logic [NBLK-1:0]  nxt_c;
    logic [NBLK-1:0]  nxt_cmsb;

    logic advance;

    // Whole pipeline moves unless a finished result is waiting on the consumer
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Block k lookahead evaluated from stage k contents
    generate
        for (genvar k = 0; k < NBLK; k++) begin : g_blk
            localparam logic [WIDTH-1:0] BLK_MASK = WIDTH'({BLOCK{1'b1}}) << (k * BLOCK);

            logic [BLOCK-1:0] a_blk;
            logic [BLOCK-1:0] b_blk;
            logic [BLOCK-1:0] g;
            logic [BLOCK-1:0] p;
            logic [BLOCK:0]   c;
            logic [BLOCK-1:0] s_blk;

            assign a_blk = stg_a[k][k*BLOCK +: BLOCK];
            assign b_blk = stg_b[k][k*BLOCK +: BLOCK];
            assign g     = a_blk & b_blk;
            assign p     = a_blk ^ b_blk;
            assign c[0]  = stg_c[k];

            for (genvar i = 0; i < BLOCK; i++) begin : g_bit
                assign c[i+1] = g[i] | (p[i] & c[i]);
            end

            assign s_blk       = p ^ c[BLOCK-1:0];
            assign nxt_sum[k]  = (stg_sum[k] & ~BLK_MASK) | (WIDTH'(s_blk) << (k * BLOCK));
            assign nxt_c[k]    = c[BLOCK];
            assign nxt_cmsb[k] = c[BLOCK-1];
        end
    endgenerate

    // Pipeline stage registers: load on advance, hold on stall, clear valids on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_vld <= '0;
            stg_c   <= '0;
            for (int k = 0; k < NBLK; k++) begin
                stg_a[k]   <= '0;
                stg_b[k]   <= '0;
                stg_sum[k] <= '0;
            end
        end else if (advance) begin
            stg_vld[0] <= in_valid;
            stg_a[0]   <= in_a;
            stg_b[0]   <= in_sub ? ~in_b : in_b;
            stg_c[0]   <= in_sub | in_cin;
            stg_sum[0] <= '0;
            for (int k = 1; k < NBLK; k++) begin
                stg_vld[k] <= stg_vld[k-1];
                stg_a[k]   <= stg_a[k-1];
                stg_b[k]   <= stg_b[k-1];
                stg_c[k]   <= nxt_c[k-1];
                stg_sum[k] <= nxt_sum[k-1];
            end
        end
    end

    // Output register: completes the last block and forms the flags; data holds across bubbles
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            out_valid <= stg_vld[NBLK-1];
            if (stg_vld[NBLK-1]) begin
                out_sum  <= nxt_sum[NBLK-1];
                out_cout <= nxt_c[NBLK-1];
                out_ovf  <= nxt_c[NBLK-1] ^ nxt_cmsb[NBLK-1];
                out_zero <= (nxt_sum[NBLK-1] == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH=32, BLOCK=8).
module tb_pipelined_cla_addsub;

    localparam int unsigned W    = 32;
    localparam int unsigned BLK  = 8;
    localparam int unsigned NBLK = W / BLK;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } beat_t;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(BLK)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    res_t model_q[$];

    // Values sampled just before each rising edge by cycle()
    bit   s_ov, s_ordy, s_ir, s_ix, s_ox, s_under;
    res_t s_got, s_exp;

    // Reference: plain (W+1)-bit arithmetic, overflow from operand/result signs
    function automatic res_t ref_model(beat_t bt);
        res_t         r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = bt.sub ? ~bt.b : bt.b;
        full   = {1'b0, bt.a} + {1'b0, bb} + (W+1)'(bt.sub ? 1'b1 : bt.cin);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.zero = (r.sum == '0);
        r.ovf  = (bt.a[W-1] == bb[W-1]) && (r.sum[W-1] != bt.a[W-1]);
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t bt;
        bt.a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
        bt.b   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
        bt.cin = 1'($urandom_range(0, 1));
        bt.sub = 1'($urandom_range(0, 1));
        return bt;
    endfunction

    task automatic drive(input beat_t bt, input bit v);
        in_valid = v;
        in_a     = bt.a;
        in_b     = bt.b;
        in_cin   = bt.cin;
        in_sub   = bt.sub;
    endtask

    // One clock: sample handshakes and outputs, update the scoreboard, then step past the edge
    task automatic cycle();
        #2;
        s_ov    = out_valid;
        s_ordy  = out_ready;
        s_ir    = in_ready;
        s_got   = {out_sum, out_cout, out_ovf, out_zero};
        s_ox    = !reset && out_valid && out_ready;
        s_ix    = !reset && in_valid && in_ready;
        s_under = 1'b0;
        s_exp   = '0;
        if (reset) begin
            model_q.delete();
        end else begin
            if (s_ox) begin
                if (model_q.size() == 0) s_under = 1'b1;
                else s_exp = model_q.pop_front();
            end
            if (s_ix) model_q.push_back(ref_model({in_a, in_b, in_cin, in_sub}));
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    // Send one beat and wait for its result (bounded); ok=0 on timeout
    task automatic run_one(input beat_t bt, output res_t r, output bit ok);
        ok = 1'b0;
        r  = '0;
        out_ready = 1'b1;
        drive(bt, 1'b1);
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (s_ix) break;
        end
        in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (s_ox) begin
                r  = s_got;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        drive('0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_tests++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %h/%b%b%b exp 0", out_sum, out_cout, out_ovf, out_zero);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_single_add();
        res_t exp_r;
        drive('{a: 32'h5, b: 32'h3, cin: 1'b0, sub: 1'b0}, 1'b1);
        cycle();
        n_tests++;
        if (s_ix !== 1'b1) begin n_fail++; $display("FAIL add_accept: got %b exp 1", s_ix); end
        in_valid = 1'b0;
        for (int j = 1; j <= int'(NBLK); j++) begin
            cycle();
            n_tests++;
            if (out_valid !== (j == int'(NBLK))) begin
                n_fail++; $display("FAIL add_latency_%0d: got %b exp %b", j, out_valid, (j == int'(NBLK)));
            end
        end
        exp_r = '{sum: 32'h8, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        n_tests++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== exp_r) begin
            n_fail++; $display("FAIL add_5_3: got %h exp %h", {out_sum, out_cout, out_ovf, out_zero}, exp_r);
        end
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_ripple();
        res_t r;
        bit   ok;
        run_one('{a: 32'hFFFF_FFFF, b: 32'h0, cin: 1'b1, sub: 1'b0}, r, ok);
        n_tests++;
        if (!ok || r !== '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1}) begin
            n_fail++; $display("FAIL ripple_cin: got %h ok %b exp sum 0 c1 v0 z1", r, ok);
        end
        run_one('{a: 32'hFFFF_FFFF, b: 32'h1, cin: 1'b0, sub: 1'b0}, r, ok);
        n_tests++;
        if (!ok || r !== '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1}) begin
            n_fail++; $display("FAIL wrap_plus1: got %h ok %b exp sum 0 c1 v0 z1", r, ok);
        end
        run_one('{a: 32'h7FFF_FFFF, b: 32'h1, cin: 1'b0, sub: 1'b0}, r, ok);
        n_tests++;
        if (!ok || r !== '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0}) begin
            n_fail++; $display("FAIL add_ovf: got %h ok %b exp sum 80000000 c0 v1 z0", r, ok);
        end
    endtask

    task automatic test_sub();
        res_t r;
        bit   ok;
        run_one('{a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b0, sub: 1'b1}, r, ok);
        n_tests++;
        if (!ok || r !== '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0}) begin
            n_fail++; $display("FAIL sub_ovf: got %h ok %b exp sum 80000000 c0 v1 z0", r, ok);
        end
        // carry-in must be ignored when subtracting
        run_one('{a: 32'h5, b: 32'h5, cin: 1'b1, sub: 1'b1}, r, ok);
        n_tests++;
        if (!ok || r !== '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1}) begin
            n_fail++; $display("FAIL sub_equal: got %h ok %b exp sum 0 c1 v0 z1", r, ok);
        end
        run_one('{a: 32'h3, b: 32'h5, cin: 1'b0, sub: 1'b1}, r, ok);
        n_tests++;
        if (!ok || r !== '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0}) begin
            n_fail++; $display("FAIL sub_borrow: got %h ok %b exp sum fffffffe c0 v0 z0", r, ok);
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0, got = 0, first_in = -1, first_out = -1, last_out = -1;
        bit gap = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 60 && got < 16; t++) begin
            if (issued < 16) drive(rand_beat(), 1'b1);
            else in_valid = 1'b0;
            cycle();
            if (s_ix) begin
                if (first_in < 0) first_in = cyc;
                issued++;
            end
            if (s_ox) begin
                n_tests++;
                if (s_under || s_got !== s_exp) begin
                    n_fail++; $display("FAIL b2b_beat_%0d: got %h exp %h extra %b", got, s_got, s_exp, s_under);
                end
                if (first_out < 0) first_out = cyc;
                else if (cyc != last_out + 1) gap = 1'b1;
                last_out = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 16 || model_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results, %0d left, exp 16 and 0", got, model_q.size());
        end
        n_tests++;
        if (gap || first_out != first_in + int'(NBLK) + 1) begin
            n_fail++; $display("FAIL b2b_timing: first_out %0d gap %b exp %0d no gap", first_out, gap, first_in + int'(NBLK) + 1);
        end
    endtask

    task automatic test_stall();
        beat_t cur;
        res_t  held;
        int    issued = 0, got = 0, stalls = 0;
        cur = rand_beat();
        held = '0;
        for (int t = 0; t < 100 && got < 20; t++) begin
            if (issued < 20) drive(cur, 1'b1);
            else in_valid = 1'b0;
            out_ready = !(got == 4 && stalls < 3);
            cycle();
            if (!s_ordy) begin
                stalls++;
                n_tests++;
                if (s_ov !== 1'b1 || s_ir !== 1'b0 || s_ix) begin
                    n_fail++; $display("FAIL stall_hs_%0d: out_valid %b in_ready %b exp 1 0", stalls, s_ov, s_ir);
                end
                if (stalls == 1) held = s_got;
                else begin
                    n_tests++;
                    if (s_got !== held) begin
                        n_fail++; $display("FAIL stall_hold_%0d: got %h exp %h", stalls, s_got, held);
                    end
                end
            end
            if (s_ix) begin
                issued++;
                cur = rand_beat();
            end
            if (s_ox) begin
                n_tests++;
                if (s_under || s_got !== s_exp) begin
                    n_fail++; $display("FAIL stall_beat_%0d: got %h exp %h extra %b", got, s_got, s_exp, s_under);
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (got != 20 || stalls != 3 || model_q.size() != 0) begin
            n_fail++; $display("FAIL stall_count: got %0d stalls %0d left %0d exp 20 3 0", got, stalls, model_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(rand_beat(), 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        cycle();
        reset = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_flight: valid %b sum %h ready %b exp 0 0 1", out_valid, out_sum, in_ready);
        end
        drive(rand_beat(), 1'b1);
        cycle();
        in_valid = 1'b0;
        for (int j = 1; j <= int'(NBLK); j++) begin
            cycle();
            n_tests++;
            if (out_valid !== (j == int'(NBLK))) begin
                n_fail++; $display("FAIL rst_next_lat_%0d: got %b exp %b", j, out_valid, (j == int'(NBLK)));
            end
        end
        cycle();
        n_tests++;
        if (!s_ox || s_under || s_got !== s_exp || model_q.size() != 0) begin
            n_fail++; $display("FAIL rst_next_beat: got %h exp %h xfer %b", s_got, s_exp, s_ox);
        end
    endtask

    // Last-resort guard against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_ripple();
        test_sub();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
